branch_resolve_unit: RTL and testbench

- Memory-stage counterpart of the dual-issue branch predictor.
- Takes the two resolved branch slots and the prediction that was carried down the pipeline with each one. It detects mispredictions and issues a redirect PC and a flush.
- Drives the predictor's training/update interface, one cycle registered.
- Keeps saturating branch and mispredict counters for performance readout.

---
 rtl/branch_resolve_unit_if.sv | 46 ++++
 rtl/branch_resolve_unit.sv | 136 +++++++++++++
 tb/tb_branch_resolve_unit.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/branch_resolve_unit_if.sv
// Bundle between the memory stage and branch_resolve_unit.
//   Resolved slots   : valid/isBranch/taken, carried prediction, pc, target
//   Predictor update : updBranch/updTaken/updPc/updTarget per slot
//   Control          : mispredict, redirectPC, flush
//   Performance      : branchCount, mispredCount
// master = pipeline side (drives the slots), slave = branch_resolve_unit.
interface branch_resolve_unit_if #(
    parameter int PC_W  = 9,
    parameter int CNT_W = 16
);
    logic             valid1,      valid2;
    logic             isBranch1,   isBranch2;
    logic             taken1,      taken2;
    logic             predTaken1,  predTaken2;
    logic [PC_W-1:0]  predTarget1, predTarget2;
    logic [PC_W-1:0]  pc1,         pc2;
    logic [PC_W-1:0]  target1,     target2;

    logic             updBranch1,  updBranch2;
    logic             updTaken1,   updTaken2;
    logic [PC_W-1:0]  updPc1,      updPc2;
    logic [PC_W-1:0]  updTarget1,  updTarget2;
    logic             mispredict;
    logic [PC_W-1:0]  redirectPC;
    logic             flush;
    logic [CNT_W-1:0] branchCount;
    logic [CNT_W-1:0] mispredCount;

    modport master (
        output valid1, valid2, isBranch1, isBranch2, taken1, taken2,
               predTaken1, predTaken2, predTarget1, predTarget2,
               pc1, pc2, target1, target2,
        input  updBranch1, updBranch2, updTaken1, updTaken2,
               updPc1, updPc2, updTarget1, updTarget2,
               mispredict, redirectPC, flush, branchCount, mispredCount
    );

    modport slave (
        input  valid1, valid2, isBranch1, isBranch2, taken1, taken2,
               predTaken1, predTaken2, predTarget1, predTarget2,
               pc1, pc2, target1, target2,
        output updBranch1, updBranch2, updTaken1, updTaken2,
               updPc1, updPc2, updTarget1, updTarget2,
               mispredict, redirectPC, flush, branchCount, mispredCount
    );
endinterface

// File: rtl/branch_resolve_unit.sv
// Memory-stage branch resolution for a dual-issue pipeline.
// Detects mispredictions on the two resolved slots, issues a one-cycle
// mispredict pulse with the redirect PC, holds flush for FLUSH_CYCLES, trains
// the predictor one cycle later and keeps saturating performance counters.
//
// Ports:
//   clk   : system clock
//   reset : asynchronous active-low reset
//   bus   : branch_resolve_unit_if.slave (slot inputs, update/control/perf outputs)
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | resolving branches; live slots are processed
// FLUSH | squashing younger stages; all slot inputs ignored
module branch_resolve_unit #(
    parameter int PC_W         = 9,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic clk,
    input  logic reset,
    branch_resolve_unit_if.slave bus
);

    localparam int FC_W = 4;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } state_t;

    state_t           state;
    logic [FC_W-1:0]  flush_cnt;

    logic             live1, live2, proc2;
    logic             mp1, mp2, any_mp;
    logic [PC_W-1:0]  fix_pc1, fix_pc2, redirect_nxt;
    logic [1:0]       n_proc;
    logic [CNT_W:0]   branch_sum;
    logic [CNT_W-1:0] branch_nxt, mispred_nxt;

    always_comb begin
        live1 = (state == IDLE) && bus.valid1 && bus.isBranch1;
        live2 = (state == IDLE) && bus.valid2 && bus.isBranch2;

        // Targets only matter when the branch was actually taken.
        mp1 = live1 && ((bus.predTaken1 != bus.taken1) ||
                        (bus.taken1 && (bus.predTarget1 != bus.target1)));

        // A mispredicting older slot makes slot2 wrong-path.
        proc2 = live2 && !mp1;
        mp2   = proc2 && ((bus.predTaken2 != bus.taken2) ||
                          (bus.taken2 && (bus.predTarget2 != bus.target2)));

        any_mp = mp1 || mp2;

        fix_pc1 = bus.taken1 ? bus.target1 : bus.pc1 + PC_W'(1);
        fix_pc2 = bus.taken2 ? bus.target2 : bus.pc2 + PC_W'(1);
        redirect_nxt = mp1 ? fix_pc1 : fix_pc2;

        n_proc     = {1'b0, live1} + {1'b0, proc2};
        branch_sum = {1'b0, bus.branchCount} + {{(CNT_W-1){1'b0}}, n_proc};
        branch_nxt = branch_sum[CNT_W] ? {CNT_W{1'b1}} : branch_sum[CNT_W-1:0];

        mispred_nxt = bus.mispredCount;
        if (any_mp && !(&bus.mispredCount))
            mispred_nxt = bus.mispredCount + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state            <= IDLE;
            flush_cnt        <= '0;
            bus.updBranch1   <= 1'b0;
            bus.updBranch2   <= 1'b0;
            bus.updTaken1    <= 1'b0;
            bus.updTaken2    <= 1'b0;
            bus.updPc1       <= '0;
            bus.updPc2       <= '0;
            bus.updTarget1   <= '0;
            bus.updTarget2   <= '0;
            bus.mispredict   <= 1'b0;
            bus.redirectPC   <= '0;
            bus.flush        <= 1'b0;
            bus.branchCount  <= '0;
            bus.mispredCount <= '0;
        end else begin
            case (state)
                IDLE: begin
                    bus.updBranch1   <= live1;
                    bus.updBranch2   <= proc2;
                    if (live1) begin
                        bus.updTaken1  <= bus.taken1;
                        bus.updPc1     <= bus.pc1;
                        bus.updTarget1 <= bus.target1;
                    end
                    if (proc2) begin
                        bus.updTaken2  <= bus.taken2;
                        bus.updPc2     <= bus.pc2;
                        bus.updTarget2 <= bus.target2;
                    end
                    bus.mispredict   <= any_mp;
                    bus.branchCount  <= branch_nxt;
                    bus.mispredCount <= mispred_nxt;
                    if (any_mp) begin
                        bus.redirectPC <= redirect_nxt;
                        bus.flush      <= 1'b1;
                        flush_cnt      <= FC_W'(FLUSH_CYCLES);
                        state          <= FLUSH;
                    end else begin
                        bus.flush      <= 1'b0;
                    end
                end
                FLUSH: begin
                    bus.updBranch1 <= 1'b0;
                    bus.updBranch2 <= 1'b0;
                    bus.mispredict <= 1'b0;
                    // flush_cnt counts the flush cycles still to be shown,
                    // including the current one.
                    if (flush_cnt == FC_W'(1)) begin
                        bus.flush <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        flush_cnt <= flush_cnt - FC_W'(1);
                        bus.flush <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    bus.flush <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: directed scenarios, random
// traffic against a behavioural model, mid-flush reset and counter saturation.
module tb_branch_resolve_unit;

    localparam int PC_W         = 9;
    localparam int FLUSH_CYCLES = 2;
    localparam int CNT_W        = 16;
    localparam int PC_MOD       = 1 << PC_W;
    localparam int CNT_MAX      = (1 << CNT_W) - 1;

    logic clk;
    logic reset;

    branch_resolve_unit_if #(.PC_W(PC_W), .CNT_W(CNT_W)) bus ();

    branch_resolve_unit #(
        .PC_W(PC_W), .FLUSH_CYCLES(FLUSH_CYCLES), .CNT_W(CNT_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    bit sparse   = 1'b0;
    int tick_no  = 0;

    // model state: expected outputs after the next active edge
    int m_flush_left;
    int e_ub1, e_ub2, e_ut1, e_ut2, e_upc1, e_upc2, e_utg1, e_utg2;
    int e_mp, e_redir, e_flush, e_bc, e_mc;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
    endtask

    task automatic model_reset();
        m_flush_left = 0;
        e_ub1 = 0; e_ub2 = 0; e_ut1 = 0; e_ut2 = 0;
        e_upc1 = 0; e_upc2 = 0; e_utg1 = 0; e_utg2 = 0;
        e_mp = 0; e_redir = 0; e_flush = 0; e_bc = 0; e_mc = 0;
    endtask

    function automatic bit wrong(input bit t, input bit pt, input int tg, input int ptg);
        return (t != pt) || (t && (tg != ptg));
    endfunction

    task automatic model_eval();
        bit live1, live2, mp1, mp2, p2;
        if (m_flush_left > 0) begin
            m_flush_left--;
            e_flush = (m_flush_left > 0);
            e_ub1 = 0; e_ub2 = 0; e_mp = 0;
        end else begin
            live1 = bus.valid1 && bus.isBranch1;
            live2 = bus.valid2 && bus.isBranch2;
            mp1 = live1 && wrong(bus.taken1, bus.predTaken1, int'(bus.target1), int'(bus.predTarget1));
            p2  = live2 && !mp1;
            mp2 = p2 && wrong(bus.taken2, bus.predTaken2, int'(bus.target2), int'(bus.predTarget2));
            e_ub1 = live1;
            e_ub2 = p2;
            if (live1) begin
                e_ut1 = bus.taken1; e_upc1 = bus.pc1; e_utg1 = bus.target1;
            end
            if (p2) begin
                e_ut2 = bus.taken2; e_upc2 = bus.pc2; e_utg2 = bus.target2;
            end
            e_mp = mp1 || mp2;
            if (mp1)      e_redir = bus.taken1 ? int'(bus.target1) : (int'(bus.pc1) + 1) % PC_MOD;
            else if (mp2) e_redir = bus.taken2 ? int'(bus.target2) : (int'(bus.pc2) + 1) % PC_MOD;
            e_bc = e_bc + int'(live1) + int'(p2);
            if (e_bc > CNT_MAX) e_bc = CNT_MAX;
            e_mc = e_mc + e_mp;
            if (e_mc > CNT_MAX) e_mc = CNT_MAX;
            if (e_mp) begin
                m_flush_left = FLUSH_CYCLES;
                e_flush = 1;
            end else begin
                e_flush = 0;
            end
        end
    endtask

    task automatic compare_all();
        chk("updBranch1",   bus.updBranch1,   e_ub1);
        chk("updBranch2",   bus.updBranch2,   e_ub2);
        chk("updTaken1",    bus.updTaken1,    e_ut1);
        chk("updTaken2",    bus.updTaken2,    e_ut2);
        chk("updPc1",       bus.updPc1,       e_upc1);
        chk("updPc2",       bus.updPc2,       e_upc2);
        chk("updTarget1",   bus.updTarget1,   e_utg1);
        chk("updTarget2",   bus.updTarget2,   e_utg2);
        chk("mispredict",   bus.mispredict,   e_mp);
        chk("redirectPC",   bus.redirectPC,   e_redir);
        chk("flush",        bus.flush,        e_flush);
        chk("branchCount",  bus.branchCount,  e_bc);
        chk("mispredCount", bus.mispredCount, e_mc);
    endtask

    // Inputs are set at a falling edge; the model predicts the coming rising
    // edge and outputs are compared at the next falling edge.
    task automatic tick();
        model_eval();
        @(negedge clk);
        tick_no++;
        if (!sparse || (tick_no % 1024 == 0)) compare_all();
    endtask

    task automatic set_slot(input int k, input bit v, input bit b, input bit t,
                            input bit pt, input int ptg, input int pc, input int tg);
        if (k == 1) begin
            bus.valid1 = v; bus.isBranch1 = b; bus.taken1 = t; bus.predTaken1 = pt;
            bus.predTarget1 = PC_W'(ptg); bus.pc1 = PC_W'(pc); bus.target1 = PC_W'(tg);
        end else begin
            bus.valid2 = v; bus.isBranch2 = b; bus.taken2 = t; bus.predTaken2 = pt;
            bus.predTarget2 = PC_W'(ptg); bus.pc2 = PC_W'(pc); bus.target2 = PC_W'(tg);
        end
    endtask

    task automatic idle_inputs();
        set_slot(1, 0, 0, 0, 0, 0, 0, 0);
        set_slot(2, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic rand_slot(input int k);
        bit t, pt;
        int tg, ptg, pc;
        t   = 1'($urandom_range(0, 1));
        pt  = ($urandom_range(0, 3) == 0) ? !t : t;
        tg  = $urandom_range(0, PC_MOD - 1);
        ptg = ($urandom_range(0, 3) == 0) ? $urandom_range(0, PC_MOD - 1) : tg;
        pc  = ($urandom_range(0, 15) == 0) ? PC_MOD - 1 : $urandom_range(0, PC_MOD - 1);
        set_slot(k, $urandom_range(0, 7) != 0, $urandom_range(0, 3) != 0, t, pt, ptg, pc, tg);
    endtask

    // Called at a falling edge: reset asynchronously, check, release on the
    // next falling edge with idle inputs.
    task automatic async_reset();
        #1 reset = 1'b0;
        #1;
        model_reset();
        compare_all();
        idle_inputs();
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0;
        idle_inputs();
        model_reset();
        @(negedge clk);
        @(negedge clk);
        compare_all();
        reset = 1'b1;

        // correct taken branch
        set_slot(1, 1, 1, 1, 1, 'h040, 'h010, 'h040);
        tick();
        chk("t1_updBranch1", bus.updBranch1, 1);
        chk("t1_updTarget1", bus.updTarget1, 'h040);
        chk("t1_mispredict", bus.mispredict, 0);
        chk("t1_branchCount", bus.branchCount, 1);

        // direction mispredict on slot1, slot2 is wrong-path
        set_slot(1, 1, 1, 1, 0, 'h000, 'h020, 'h080);
        set_slot(2, 1, 1, 1, 1, 'h033, 'h021, 'h033);
        tick();
        chk("t2_mispredict", bus.mispredict, 1);
        chk("t2_redirectPC", bus.redirectPC, 'h080);
        chk("t2_updBranch2", bus.updBranch2, 0);
        chk("t2_branchCount", bus.branchCount, 2);
        chk("t2_mispredCount", bus.mispredCount, 1);
        chk("t2_flush0", bus.flush, 1);
        idle_inputs();
        tick();
        chk("t2_flush1", bus.flush, 1);
        chk("t2_pulse", bus.mispredict, 0);
        tick();
        chk("t2_flush_end", bus.flush, 0);

        // slot1 correct not-taken, slot2 mispredicts at pc 0x1FF -> wrap
        set_slot(1, 1, 1, 0, 0, 'h011, 'h100, 'h150);
        set_slot(2, 1, 1, 0, 1, 'h055, 'h1FF, 'h055);
        tick();
        chk("t3_upd_both", {bus.updBranch1, bus.updBranch2}, 2'b11);
        chk("t3_redirect_wrap", bus.redirectPC, 'h000);
        chk("t3_branchCount", bus.branchCount, 4);
        chk("t3_mispredCount", bus.mispredCount, 2);
        // live branches during FLUSH are ignored
        set_slot(1, 1, 1, 1, 0, 'h000, 'h0A0, 'h0B0);
        tick();
        tick();
        chk("t3_flush_ignored", bus.branchCount, 4);
        chk("t3_flush_no_upd", bus.updBranch1, 0);

        // target-only mispredict
        set_slot(1, 1, 1, 1, 1, 'h020, 'h004, 'h024);
        idle_inputs();
        set_slot(1, 1, 1, 1, 1, 'h020, 'h004, 'h024);
        tick();
        chk("t4_mispredict", bus.mispredict, 1);
        chk("t4_redirectPC", bus.redirectPC, 'h024);
        set_slot(2, 1, 1, 0, 0, 'h000, 'h006, 'h000);
        tick();
        tick();
        chk("t4_cnt_frozen", bus.branchCount, 5);

        // reset in the first FLUSH cycle
        idle_inputs();
        set_slot(1, 1, 1, 0, 1, 'h010, 'h030, 'h010);
        tick();
        chk("t5_flush_pre", bus.flush, 1);
        async_reset();
        set_slot(1, 1, 1, 1, 1, 'h0C0, 'h0B0, 'h0C0);
        tick();
        chk("t5_after_reset_upd", bus.updBranch1, 1);
        chk("t5_after_reset_cnt", bus.branchCount, 1);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            rand_slot(1);
            rand_slot(2);
            tick();
        end

        // saturation: two correct branches per cycle from zero
        async_reset();
        set_slot(1, 1, 1, 1, 1, 'h012, 'h010, 'h012);
        set_slot(2, 1, 1, 0, 0, 'h000, 'h011, 'h000);
        sparse = 1'b1;
        for (int i = 0; i < (CNT_MAX - 1) / 2; i++) tick();
        sparse = 1'b0;
        chk("sat_fffe", bus.branchCount, CNT_MAX - 1);
        tick();
        chk("sat_ffff", bus.branchCount, CNT_MAX);
        for (int i = 0; i < 3; i++) tick();
        chk("sat_hold", bus.branchCount, CNT_MAX);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
